controlador_notas: RTL and testbench

Note sequencer that plays the song chosen by the song-selection FSM. On each start pulse it latches the 2-bit song select and walks that song's words in synchronous-read note memory. It holds each note for its encoded duration, measured in tempo ticks. At the song's end marker it pulses force_prox so the selector advances to the next song.

---
 rtl/controlador_notas.sv | 107 ++++++++++
 tb/tb_controlador_notas.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_notas.sv
// Note sequencer: walks the selected song's words in note memory, holding each note for
// duration*TICKS_PER_UNIT tempo ticks, and pulses force_prox when the song ends.
module controlador_notas #(
  parameter int IDX_BITS       = 6,
  parameter int TICKS_PER_UNIT = 4,
  parameter int NOTE_BITS      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             select,
  input  logic                   pause,
  input  logic                   tick,
  input  logic [NOTE_BITS+3:0]   mem_data,
  output logic [IDX_BITS+1:0]    mem_addr,
  output logic [NOTE_BITS-1:0]   note,
  output logic                   note_valid,
  output logic                   playing,
  output logic                   force_prox
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_READ  = 3'd2,
    S_PLAY  = 3'd3,
    S_END   = 3'd4
  } state_t;

  localparam logic [7:0]          UNIT_RELOAD = 8'(TICKS_PER_UNIT - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST    = '1;

  state_t              state;
  logic [1:0]          song;
  logic [IDX_BITS-1:0] index;
  logic [IDX_BITS-1:0] idx_next;
  logic [3:0]          dur_cnt;
  logic [7:0]          unit_cnt;
  logic [3:0]          mem_dur;

  assign idx_next = index + IDX_BITS'(1);
  assign mem_dur  = mem_data[3:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      song     <= 2'd0;
      index    <= '0;
      mem_addr <= '0;
      note     <= '0;
      dur_cnt  <= 4'd0;
      unit_cnt <= 8'd0;
    end else if (start) begin
      // A new song always wins, including over a pending end-of-song.
      state    <= S_FETCH;
      song     <= select;
      index    <= '0;
      mem_addr <= {select, {IDX_BITS{1'b0}}};
      note     <= '0;
      dur_cnt  <= 4'd0;
      unit_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: state <= S_IDLE;
        S_FETCH: state <= S_READ;
        S_READ: begin
          if (mem_dur == 4'd0) begin
            state <= S_END;
          end else begin
            note     <= mem_data[NOTE_BITS+3:4];
            dur_cnt  <= mem_dur;
            unit_cnt <= UNIT_RELOAD;
            state    <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick && !pause) begin
            if (unit_cnt != 8'd0) begin
              unit_cnt <= unit_cnt - 8'd1;
            end else if (dur_cnt > 4'd1) begin
              dur_cnt  <= dur_cnt - 4'd1;
              unit_cnt <= UNIT_RELOAD;
            end else begin
              note    <= '0;
              dur_cnt <= 4'd0;
              // The last word of a song's space ends it rather than spilling into the next song.
              if (index == IDX_LAST) begin
                state <= S_END;
              end else begin
                index    <= idx_next;
                mem_addr <= {song, idx_next};
                state    <= S_FETCH;
              end
            end
          end
        end
        S_END: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign note_valid = (state == S_PLAY) && !pause;
  assign playing    = (state == S_FETCH) || (state == S_READ) || (state == S_PLAY);
  assign force_prox = (state == S_END) && !start;

endmodule

// File: tb/tb_controlador_notas.sv
// Bench for controlador_notas: memory model, free-running tempo ticks, a negedge monitor
// feeding observed notes/addresses/gaps, and per-scenario tasks comparing against expectations.
`timescale 1ns/1ps
module tb_controlador_notas;

  localparam int IDX_BITS = 6;
  localparam int TPU      = 2;
  localparam int NB       = 4;

  typedef struct packed {
    logic [3:0] n;
    logic [7:0] t;
  } rec_t;

  logic                clk = 1'b0;
  logic                reset, start, pause, tick;
  logic [1:0]          select;
  logic [NB+3:0]       mem_data;
  logic [IDX_BITS+1:0] mem_addr;
  logic [NB-1:0]       note;
  logic                note_valid, playing, force_prox;

  logic [7:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  rec_t       exp_q[$], obs_q[$];
  logic [7:0] exp_addr[$], obs_addr[$];
  int         obs_gap[$];
  logic [3:0] cur_note;
  int         cur_ticks, gap_cnt, fp_pulses, fp_long, nv_cycles;
  bit         prev_nv, prev_play, prev_fp;

  controlador_notas #(.IDX_BITS(IDX_BITS), .TICKS_PER_UNIT(TPU), .NOTE_BITS(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .select(select), .pause(pause), .tick(tick),
    .mem_data(mem_data), .mem_addr(mem_addr), .note(note), .note_valid(note_valid),
    .playing(playing), .force_prox(force_prox)
  );

  always #5 clk = ~clk;

  // Synchronous-read note memory, one cycle of latency.
  initial begin
    mem_data = '0;
    forever begin
      @(posedge clk);
      mem_data <= mem[mem_addr];
    end
  end

  initial begin
    int ph;
    tick = 1'b0;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 4;
      tick = (ph == 0);
    end
  end

  initial begin
    prev_nv = 0; prev_play = 0; prev_fp = 0;
    cur_note = '0; cur_ticks = 0; gap_cnt = 0; fp_pulses = 0; fp_long = 0; nv_cycles = 0;
    forever begin
      @(negedge clk);
      if (note_valid) begin
        cur_note = note;
        nv_cycles++;
        if (tick) cur_ticks++;
      end
      if (prev_nv && !note_valid && !pause) begin
        obs_q.push_back('{n: cur_note, t: 8'(cur_ticks)});
        cur_ticks = 0;
      end
      if (playing && !note_valid && !pause && (!prev_play || prev_nv)) obs_addr.push_back(mem_addr);
      if (!playing) gap_cnt = 0;
      else if (!note_valid && !pause) gap_cnt++;
      if (note_valid && !prev_nv && gap_cnt > 0) begin
        obs_gap.push_back(gap_cnt);
        gap_cnt = 0;
      end
      if (force_prox) begin
        fp_pulses++;
        if (prev_fp) fp_long++;
      end
      prev_nv = note_valid; prev_play = playing; prev_fp = force_prox;
    end
  end

  task automatic flush();
    obs_q.delete(); exp_q.delete(); obs_addr.delete(); exp_addr.delete(); obs_gap.delete();
    cur_ticks = 0;
  endtask

  task automatic load_song0();
    mem[8'h00] = 8'h53; mem[8'h01] = 8'h71; mem[8'h02] = 8'h00;
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    @(posedge clk); #1 start = 1'b1; select = sel;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_fp(input int budget, output int cyc, output bit ok);
    cyc = 0; ok = 0;
    while (cyc < budget && !ok) begin
      @(negedge clk);
      cyc++;
      if (force_prox) ok = 1;
    end
  endtask

  task automatic wait_nv(input int budget, output bit ok);
    int c;
    c = 0; ok = 0;
    while (c < budget && !ok) begin
      @(negedge clk);
      c++;
      if (note_valid) ok = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; pause = 1'b0; select = 2'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_addr, note, note_valid, playing, force_prox} !== '0)
      begin failures++; $display("FAIL reset_outputs got=%0h want=0", {mem_addr, note, note_valid, playing, force_prox}); end
    @(posedge clk); #1 reset = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (playing !== 1'b0) begin failures++; $display("FAIL reset_idle playing got=%b want=0", playing); end
  endtask

  task automatic test_basic();
    int cyc; bit ok; rec_t e, o; int fp0;
    load_song0();
    flush();
    exp_q.push_back('{n: 4'h5, t: 8'd6}); exp_q.push_back('{n: 4'h7, t: 8'd2});
    exp_addr.push_back(8'h00); exp_addr.push_back(8'h01); exp_addr.push_back(8'h02);
    fp0 = fp_pulses;
    pulse_start(2'd0);
    @(negedge clk);
    checks++;
    if (mem_addr !== 8'h00 || playing !== 1'b1 || note_valid !== 1'b0)
      begin failures++; $display("FAIL basic_fetch addr=%0h play=%b nv=%b want 0/1/0", mem_addr, playing, note_valid); end
    @(negedge clk);
    checks++;
    if (note_valid !== 1'b0) begin failures++; $display("FAIL basic_read_nv got=%b want=0", note_valid); end
    @(negedge clk);
    checks++;
    if (note_valid !== 1'b1 || note !== 4'h5)
      begin failures++; $display("FAIL basic_first_note nv=%b note=%0h want 1/5", note_valid, note); end
    wait_fp(300, cyc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_force_prox timeout after %0d cycles", cyc); end
    @(negedge clk);
    checks++;
    if (force_prox !== 1'b0 || playing !== 1'b0 || mem_addr !== 8'h02)
      begin failures++; $display("FAIL basic_after_end fp=%b play=%b addr=%0h want 0/0/02", force_prox, playing, mem_addr); end
    checks++;
    if (fp_pulses - fp0 != 1 || fp_long != 0)
      begin failures++; $display("FAIL basic_fp_pulse pulses=%0d long=%0d want 1/0", fp_pulses - fp0, fp_long); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin failures++; $display("FAIL basic_note got=%0h/%0d want=%0h/%0d", o.n, o.t, e.n, e.t); end
    end
    checks++;
    if (obs_addr != exp_addr) begin failures++; $display("FAIL basic_addr_seq got=%p want=%p", obs_addr, exp_addr); end
    checks++;
    if (obs_gap.size() != 2 || obs_gap[0] != 2 || obs_gap[1] != 2)
      begin failures++; $display("FAIL basic_gaps got=%p want='{2,2}", obs_gap); end
  endtask

  task automatic test_song_base();
    int cyc; bit ok; int nv0;
    mem[8'h80] = 8'h00;
    flush();
    nv0 = nv_cycles;
    pulse_start(2'd2);
    @(negedge clk);
    checks++;
    if (mem_addr !== 8'h80) begin failures++; $display("FAIL base_addr got=%0h want=80", mem_addr); end
    wait_fp(20, cyc, ok);
    checks++;
    if (!ok || cyc != 2) begin failures++; $display("FAIL base_end_timing ok=%b cyc=%0d want 1/2", ok, cyc); end
    @(negedge clk);
    checks++;
    if (nv_cycles != nv0 || playing !== 1'b0)
      begin failures++; $display("FAIL base_no_note nv_cycles=%0d play=%b want 0/0", nv_cycles - nv0, playing); end
  endtask

  task automatic test_pause();
    int cyc; bit ok; rec_t e, o; int ptick, pnv;
    load_song0();
    flush();
    exp_q.push_back('{n: 4'h5, t: 8'd6}); exp_q.push_back('{n: 4'h7, t: 8'd2});
    pulse_start(2'd0);
    wait_nv(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pause_note_start timeout"); end
    repeat (6) @(posedge clk);
    #1 pause = 1'b1;
    ptick = 0; pnv = 0;
    repeat (10) begin
      @(negedge clk);
      if (tick) ptick++;
      if (note_valid) pnv++;
    end
    @(posedge clk); #1 pause = 1'b0;
    checks++;
    if (pnv != 0 || ptick < 2)
      begin failures++; $display("FAIL pause_window nv_cycles=%0d ticks=%0d want 0/>=2", pnv, ptick); end
    wait_fp(400, cyc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pause_force_prox timeout after %0d cycles", cyc); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin failures++; $display("FAIL pause_note got=%0h/%0d want=%0h/%0d", o.n, o.t, e.n, e.t); end
    end
  endtask

  task automatic test_restart();
    int cyc; bit ok; rec_t o; int fp0;
    load_song0();
    mem[8'h40] = 8'h12; mem[8'h41] = 8'h00;
    flush();
    fp0 = fp_pulses;
    pulse_start(2'd0);
    wait_nv(10, ok);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; select = 2'd1;
    @(posedge clk); #1 start = 1'b0; select = 2'd3;
    @(negedge clk);
    checks++;
    if (mem_addr !== 8'h40 || note_valid !== 1'b0 || playing !== 1'b1 || force_prox !== 1'b0)
      begin failures++; $display("FAIL restart_fetch addr=%0h nv=%b play=%b fp=%b want 40/0/1/0", mem_addr, note_valid, playing, force_prox); end
    #1 flush();
    wait_fp(200, cyc, ok);
    checks++;
    if (!ok || mem_addr !== 8'h41)
      begin failures++; $display("FAIL restart_song1_end ok=%b addr=%0h want 1/41", ok, mem_addr); end
    @(negedge clk);
    checks++;
    if (fp_pulses - fp0 != 1) begin failures++; $display("FAIL restart_fp_count got=%0d want=1", fp_pulses - fp0); end
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
    checks++;
    if (o !== rec_t'{n: 4'h1, t: 8'd4}) begin failures++; $display("FAIL restart_note got=%0h/%0d want=1/4", o.n, o.t); end
  endtask

  task automatic test_reset_mid_play();
    bit ok; int bad;
    load_song0();
    pulse_start(2'd0);
    wait_nv(10, ok);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_addr, note, note_valid, playing, force_prox} !== '0)
      begin failures++; $display("FAIL midreset_outputs got=%0h want=0", {mem_addr, note, note_valid, playing, force_prox}); end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (playing || note_valid) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midreset_stays_idle active_cycles=%0d want=0", bad); end
    #1 flush();
  endtask

  task automatic test_start_during_end();
    mem[8'h80] = 8'h00;
    for (int i = 0; i < 64; i++) mem[8'hC0 + i] = {4'(i), 4'h1};
    flush();
    exp_addr.push_back(8'h80);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{n: 4'(i), t: 8'd2});
      exp_addr.push_back(8'(8'hC0 + i));
    end
    @(posedge clk); #1 start = 1'b1; select = 2'd2;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b1; select = 2'd3;
    @(negedge clk);
    checks++;
    if (force_prox !== 1'b0 || playing !== 1'b0)
      begin failures++; $display("FAIL end_start_fp fp=%b play=%b want 0/0", force_prox, playing); end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_addr !== 8'hC0 || playing !== 1'b1 || force_prox !== 1'b0)
      begin failures++; $display("FAIL end_start_fetch addr=%0h play=%b fp=%b want c0/1/0", mem_addr, playing, force_prox); end
  endtask

  // Continues song 3, started from the END cycle above, through all 64 words.
  task automatic test_index_limit();
    int cyc; bit ok; rec_t e, o; int fp0, gap_bad;
    fp0 = fp_pulses;
    wait_fp(3000, cyc, ok);
    checks++;
    if (!ok || mem_addr !== 8'hFF)
      begin failures++; $display("FAIL limit_end ok=%b addr=%0h want 1/ff", ok, mem_addr); end
    @(negedge clk);
    checks++;
    if (fp_pulses - fp0 != 1 || playing !== 1'b0 || mem_addr !== 8'hFF)
      begin failures++; $display("FAIL limit_after pulses=%0d play=%b addr=%0h want 1/0/ff", fp_pulses - fp0, playing, mem_addr); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin failures++; $display("FAIL limit_note got=%0h/%0d want=%0h/%0d", o.n, o.t, e.n, e.t); end
    end
    checks++;
    if (obs_addr != exp_addr) begin failures++; $display("FAIL limit_addr_seq got_n=%0d want_n=%0d", obs_addr.size(), exp_addr.size()); end
    gap_bad = 0;
    foreach (obs_gap[i]) if (obs_gap[i] != 2) gap_bad++;
    checks++;
    if (gap_bad != 0 || obs_gap.size() != 64)
      begin failures++; $display("FAIL limit_gaps bad=%0d n=%0d want 0/64", gap_bad, obs_gap.size()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_song_base();
    test_pause();
    test_restart();
    test_reset_mid_play();
    test_start_during_end();
    test_index_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
